// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB completer holding a NUM_REGS-deep word register file at BASE_ADDR.
//   It inserts WAIT_STATES pready-low cycles in the access phase. pslverr is
//   raised on a decode miss, a misaligned address or a write to a read-only
//   register. After each committed write, wr_pulse gives a one-cycle strobe
//   for the register that was written.
//
//   Optional feature: define APB_SLV_PSTRB_EN to add the pstrb port and
//   byte-lane write masking. Without it, every write replaces the full word.
//
// Ports
//   pclk, preset_n        clock, synchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr, pwdata         byte address, write data
//   pstrb                 byte strobes (APB_SLV_PSTRB_EN only)
//   prdata, pready        read data, transfer complete
//   pslverr               transfer error, valid with pready
//   reg_q                 flat register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse              bit i high the cycle after reg i was written
//
// FSM (state_q holds the bus phase seen in the previous cycle; the
//      combinational "phase" is the bus phase of the current cycle)
//   state     | meaning
//   ST_IDLE   | no transfer, or the last transfer just completed
//   ST_SETUP  | setup phase seen; the access phase is expected next
//   ST_ACCESS | access phase in progress, waiting for wcnt to reach WAIT_STATES
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
   parameter int                  ADDR_W      = 32,
   parameter int                  DATA_W      = 32,
   parameter int                  NUM_REGS    = 8,
   parameter logic [ADDR_W-1:0]   BASE_ADDR   = 'hA000,
   parameter int                  WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                         pclk,
   input  logic                         preset_n,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W-1:0]            pwdata,
`ifdef APB_SLV_PSTRB_EN
   input  logic [DATA_W/8-1:0]          pstrb,
`endif
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          wr_pulse
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + ADDR_W'(4 * NUM_REGS);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   state_t            state_q, state_d, phase;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [IDX_W-1:0]  idx;
   logic              hit;
   logic              commit;

   // Address decode. The master holds address and data stable through the
   // access phase, so the bus is decoded directly and nothing is captured.
   always_comb begin
      hit = (paddr >= BASE_ADDR) && (paddr < END_ADDR) && (paddr[1:0] == 2'b00);
      idx = IDX_W'((paddr - BASE_ADDR) >> 2);
   end

   always_comb begin
      phase   = ST_IDLE;
      state_d = ST_IDLE;
      wcnt_d  = 4'd0;
      if (psel && !penable)
         phase = ST_SETUP;
      else if (psel && penable && (state_q != ST_IDLE))
         phase = ST_ACCESS;   // penable with no preceding setup is ignored
      pready  = preset_n && (phase == ST_ACCESS) && (wcnt_q == 4'(WAIT_STATES));
      state_d = phase;
      if (pready)
         state_d = ST_IDLE;
      else if (phase == ST_ACCESS)
         wcnt_d = wcnt_q + 4'd1;
   end

   always_comb begin
      pslverr = pready && (!hit || (pwrite && RO_MASK[idx]));
      prdata  = (pready && !pwrite && hit) ? regs[idx] : '0;
      commit  = pready && pwrite && !pslverr;
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state_q  <= ST_IDLE;
         wcnt_q   <= 4'd0;
         wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         wr_pulse <= commit ? (NUM_REGS'(1) << idx) : '0;
         if (commit) begin
`ifdef APB_SLV_PSTRB_EN
            for (int b = 0; b < DATA_W/8; b++)
               if (pstrb[b])
                  regs[idx][8*b +: 8] <= pwdata[8*b +: 8];
`else
            regs[idx] <= pwdata;
`endif
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[g*DATA_W +: DATA_W] = regs[g];
   end

endmodule
